// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared definitions for the mode-1 CPU: field widths,
//                opcode encodings and the sequencer state encoding.
//                The ALU imports the same opcode constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Field widths
    localparam int c_OPC_W  = 3;
    localparam int c_OPND_W = 5;
    localparam int c_DATA_W = 8;
    localparam int c_PC_W   = 4;

    // Opcodes, instruction bits [7:5]
    localparam logic [c_OPC_W-1:0] c_OP_ADD = 3'b000;
    localparam logic [c_OPC_W-1:0] c_OP_SUB = 3'b001;
    localparam logic [c_OPC_W-1:0] c_OP_MUL = 3'b010;
    localparam logic [c_OPC_W-1:0] c_OP_AND = 3'b011;
    localparam logic [c_OPC_W-1:0] c_OP_OR  = 3'b100;
    localparam logic [c_OPC_W-1:0] c_OP_XOR = 3'b101;
    localparam logic [c_OPC_W-1:0] c_OP_LDI = 3'b110;
    localparam logic [c_OPC_W-1:0] c_OP_HLT = 3'b111;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXEC    = 3'd3,
        ST_ADVANCE = 3'd4,
        ST_HALT    = 3'd5
    } state_e;

endpackage
`default_nettype wire

// File: rtl/seq_timeout.sv
`default_nettype none
// ============================================================================
//  Module      : seq_timeout
//  Description : ALU wait watchdog. While inactive the counter is held at
//                the load value; while active it counts down to zero and
//                then reports expiry. Expiry is qualified by i_active, so it
//                clears as soon as the FSM leaves EXEC.
//  Ports       : clock, reset_n  - clock / async active-low reset
//                i_active        - FSM is in EXEC
//                i_load_val      - cycles-to-expiry minus one
//                o_expired       - last permitted EXEC cycle without ready
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_timeout (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       i_active,
    input  logic [7:0] i_load_val,
    output logic       o_expired
);

    logic [7:0] r_cnt_q;
    logic [7:0] w_cnt_d;

    always_comb begin
        w_cnt_d = r_cnt_q;
        if (!i_active) begin
            w_cnt_d = i_load_val;
        end else if (r_cnt_q != 8'd0) begin
            w_cnt_d = r_cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt_q <= 8'd0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

    assign o_expired = i_active && (r_cnt_q == 8'd0);

endmodule
`default_nettype wire

// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_sequencer
//  Description : Fetch/decode/execute controller. Latches instructions from
//                the PC/ROM block, runs ALU ops through a valid/ready
//                handshake, holds the accumulator and pulses pc_ena once per
//                retired non-HLT instruction.
//  Ports       : clock, reset_n         - clock / async active-low reset
//                start, run, clear      - control (clear has top priority)
//                instr_in, pc_in        - instruction and PC from PC/ROM
//                pc_ena                 - PC advance pulse
//                alu_valid/op/a/b       - ALU request
//                alu_ready, alu_result  - ALU response
//                acc_out, ir_out, ir_pc - accumulator, IR, IR fetch PC
//                instr_count            - retired instructions (mod 256)
//                busy, halted, error    - status
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int ALU_TIMEOUT = 15
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    input  logic                run,
    input  logic                clear,
    input  logic [c_DATA_W-1:0] instr_in,
    input  logic [c_PC_W-1:0]   pc_in,
    output logic                pc_ena,
    output logic                alu_valid,
    output logic [c_OPC_W-1:0]  alu_op,
    output logic [c_DATA_W-1:0] alu_a,
    output logic [c_DATA_W-1:0] alu_b,
    input  logic                alu_ready,
    input  logic [c_DATA_W-1:0] alu_result,
    output logic [c_DATA_W-1:0] acc_out,
    output logic [c_DATA_W-1:0] ir_out,
    output logic [c_PC_W-1:0]   ir_pc,
    output logic [c_DATA_W-1:0] instr_count,
    output logic                busy,
    output logic                halted,
    output logic                error
);

    // Counter reaches zero on the ALU_TIMEOUT-th EXEC cycle.
    localparam logic [7:0] c_TIMEOUT_LOAD = 8'(ALU_TIMEOUT - 1);

    state_e              r_state_q, w_state_d;
    logic [c_DATA_W-1:0] r_acc_q,   w_acc_d;
    logic [c_DATA_W-1:0] r_ir_q,    w_ir_d;
    logic [c_PC_W-1:0]   r_ir_pc_q, w_ir_pc_d;
    logic [c_DATA_W-1:0] r_count_q, w_count_d;
    logic                r_error_q, w_error_d;

    logic [c_OPC_W-1:0]  w_opcode;
    logic [c_OPND_W-1:0] w_operand;
    logic                w_in_exec;
    logic                w_expired;

    assign w_opcode  = r_ir_q[c_DATA_W-1 -: c_OPC_W];
    assign w_operand = r_ir_q[c_OPND_W-1:0];
    assign w_in_exec = (r_state_q == ST_EXEC);

    seq_timeout u_timeout (
        .clock      (clock),
        .reset_n    (reset_n),
        .i_active   (w_in_exec),
        .i_load_val (c_TIMEOUT_LOAD),
        .o_expired  (w_expired)
    );

    always_comb begin
        w_state_d = r_state_q;
        w_acc_d   = r_acc_q;
        w_ir_d    = r_ir_q;
        w_ir_pc_d = r_ir_pc_q;
        w_count_d = r_count_q;
        w_error_d = r_error_q;

        if (clear) begin
            // Abandons any outstanding ALU request; ir/ir_pc are kept as debug history.
            w_state_d = ST_IDLE;
            w_acc_d   = '0;
            w_count_d = '0;
            w_error_d = 1'b0;
        end else begin
            case (r_state_q)
                ST_IDLE: begin
                    if (start) begin
                        w_state_d = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    w_ir_d    = instr_in;
                    w_ir_pc_d = pc_in;
                    w_state_d = ST_DECODE;
                end
                ST_DECODE: begin
                    if (w_opcode == c_OP_HLT) begin
                        w_state_d = ST_HALT;
                    end else if (w_opcode == c_OP_LDI) begin
                        w_acc_d   = {{(c_DATA_W-c_OPND_W){1'b0}}, w_operand};
                        w_state_d = ST_ADVANCE;
                    end else begin
                        w_state_d = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // A handshake on the final permitted cycle still wins over the timeout.
                    if (alu_ready) begin
                        w_acc_d   = alu_result;
                        w_state_d = ST_ADVANCE;
                    end else if (w_expired) begin
                        w_error_d = 1'b1;
                        w_state_d = ST_HALT;
                    end
                end
                ST_ADVANCE: begin
                    w_count_d = r_count_q + 8'd1;
                    w_state_d = run ? ST_FETCH : ST_IDLE;
                end
                ST_HALT: begin
                    w_state_d = ST_HALT;
                end
                default: begin
                    w_state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state_q <= ST_IDLE;
            r_acc_q   <= '0;
            r_ir_q    <= '0;
            r_ir_pc_q <= '0;
            r_count_q <= '0;
            r_error_q <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_acc_q   <= w_acc_d;
            r_ir_q    <= w_ir_d;
            r_ir_pc_q <= w_ir_pc_d;
            r_count_q <= w_count_d;
            r_error_q <= w_error_d;
        end
    end

    // Status and request strobes decode straight from the state register.
    assign pc_ena      = (r_state_q == ST_ADVANCE);
    assign alu_valid   = w_in_exec;
    assign busy        = (r_state_q != ST_IDLE) && (r_state_q != ST_HALT);
    assign halted      = (r_state_q == ST_HALT);

    assign alu_op      = w_opcode;
    assign alu_a       = r_acc_q;
    assign alu_b       = {{(c_DATA_W-c_OPND_W){1'b0}}, w_operand};
    assign acc_out     = r_acc_q;
    assign ir_out      = r_ir_q;
    assign ir_pc       = r_ir_pc_q;
    assign instr_count = r_count_q;
    assign error       = r_error_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_sequencer
//  Description : Directed self-checking bench for cpu_sequencer with a small
//                PC/ROM model and an ALU model with programmable ready delay.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_sequencer;

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic       start   = 1'b0;
    logic       run     = 1'b0;
    logic       clear   = 1'b0;
    logic [7:0] instr_in;
    logic [3:0] pc_in;
    logic       pc_ena;
    logic       alu_valid;
    logic [2:0] alu_op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic       alu_ready;
    logic [7:0] alu_result;
    logic [7:0] acc_out;
    logic [7:0] ir_out;
    logic [3:0] ir_pc;
    logic [7:0] instr_count;
    logic       busy;
    logic       halted;
    logic       error;

    int errors = 0;
    int checks = 0;

    logic [7:0] rom [0:15];
    logic [3:0] pc_q;
    logic [3:0] pc_wrap = 4'd3;
    int         ready_delay = 0;
    logic       never_ready = 1'b0;
    int         wait_cnt = 0;
    int         cyc = 0;
    logic [7:0] acc_log [$];
    int         ena_cyc [$];

    cpu_sequencer #(.ALU_TIMEOUT(15)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .run         (run),
        .clear       (clear),
        .instr_in    (instr_in),
        .pc_in       (pc_in),
        .pc_ena      (pc_ena),
        .alu_valid   (alu_valid),
        .alu_op      (alu_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_ready   (alu_ready),
        .alu_result  (alu_result),
        .acc_out     (acc_out),
        .ir_out      (ir_out),
        .ir_pc       (ir_pc),
        .instr_count (instr_count),
        .busy        (busy),
        .halted      (halted),
        .error       (error)
    );

    always #5 clock = ~clock;

    // PC/ROM model: PC returns to 0 on reset or clear, wraps at pc_wrap.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n)    pc_q <= 4'd0;
        else if (clear)  pc_q <= 4'd0;
        else if (pc_ena) pc_q <= (pc_q == pc_wrap) ? 4'd0 : pc_q + 4'd1;
    end
    assign pc_in    = pc_q;
    assign instr_in = rom[pc_q];

    // ALU model
    logic [15:0] prod;
    always_comb begin
        prod = 16'(alu_a) * 16'(alu_b);
        case (alu_op)
            3'b000:  alu_result = alu_a + alu_b;
            3'b001:  alu_result = alu_a - alu_b;
            3'b010:  alu_result = prod[7:0];
            3'b011:  alu_result = alu_a & alu_b;
            3'b100:  alu_result = alu_a | alu_b;
            3'b101:  alu_result = alu_a ^ alu_b;
            default: alu_result = 8'h00;
        endcase
    end
    assign alu_ready = alu_valid && !never_ready && (wait_cnt > ready_delay);

    // Monitor: EXEC cycle counter, retire log (acc value and cycle at each pc_ena).
    always @(negedge clock) begin
        cyc <= cyc + 1;
        if (!alu_valid) wait_cnt <= 0;
        else            wait_cnt <= wait_cnt + 1;
        if (pc_ena) begin
            acc_log.push_back(acc_out);
            ena_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_rom(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d,
                           input logic [3:0] wrap);
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
        rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
        pc_wrap = wrap;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        logic [59:0] all_out;
        set_rom(8'h00, 8'h00, 8'h00, 8'h00, 4'd3);
        reset_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            start = 1'($urandom); run = 1'($urandom); clear = 1'($urandom);
            rom[0] = 8'($urandom);
            tick();
        end
        all_out = {pc_ena, alu_valid, alu_op, alu_a, alu_b, acc_out, ir_out,
                   ir_pc, instr_count, busy, halted, error};
        checks++;
        if (all_out !== 60'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", all_out);
        end
        start = 1'b0; run = 1'b0; clear = 1'b0; rom[0] = 8'h00;
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if ({busy, halted, alu_valid, pc_ena} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_idle: busy/halted/valid/ena=%b expected 0000",
                     {busy, halted, alu_valid, pc_ena});
        end
    endtask

    task automatic test_program();
        logic [7:0] exp_acc [8] = '{8'd3, 8'd1, 8'd5, 8'd5, 8'd8, 8'd6, 8'd30, 8'd30};
        int  base;
        int  n;
        bit  spacing_ok;
        set_rom(8'h03, 8'h22, 8'h45, 8'h00, 4'd3);
        ready_delay = 0; never_ready = 1'b0;
        run = 1'b1;
        do_clear();
        base = acc_log.size();
        do_start();
        n = 0;
        while ((acc_log.size() - base) < 8 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if ((acc_log.size() - base) < 8) begin
            errors++;
            $display("FAIL program_timeout: retired %0d expected 8", acc_log.size() - base);
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (acc_log[base+i] !== exp_acc[i]) begin
                    errors++;
                    $display("FAIL program_acc[%0d]: got %0d expected %0d",
                             i, acc_log[base+i], exp_acc[i]);
                end
            end
            spacing_ok = 1'b1;
            for (int i = 0; i < 7; i++)
                if (ena_cyc[base+i+1] - ena_cyc[base+i] != 4) spacing_ok = 1'b0;
            checks++;
            if (!spacing_ok) begin
                errors++;
                $display("FAIL program_spacing: first gap %0d expected 4",
                         ena_cyc[base+1] - ena_cyc[base]);
            end
            checks++;
            if (instr_count !== 8'd8) begin
                errors++;
                $display("FAIL program_count: got %0d expected 8", instr_count);
            end
        end
        run = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if ({busy, instr_count, acc_out} !== {1'b0, 8'd9, 8'd33}) begin
            errors++;
            $display("FAIL program_stop: busy=%b count=%0d acc=%0d expected 0/9/33",
                     busy, instr_count, acc_out);
        end
    endtask

    // Runs from a cleared state until the sequencer leaves busy; returns the
    // number of retires and busy / EXEC cycles observed.
    task automatic run_until_idle(output int retired, output int nbusy, output int nvalid);
        int base;
        base = acc_log.size();
        do_clear();
        do_start();
        nbusy = 0; nvalid = 0;
        while (busy && nbusy < 60) begin
            nbusy++;
            if (alu_valid) nvalid++;
            tick();
        end
        retired = acc_log.size() - base;
    endtask

    task automatic test_wrap_sub();
        int r, nb, nv, base;
        set_rom(8'hC0, 8'h22, 8'hE0, 8'h00, 4'd3);
        run = 1'b1;
        base = acc_log.size();
        run_until_idle(r, nb, nv);
        checks++;
        if (r != 2 || acc_log[base] !== 8'd0 || acc_log[base+1] !== 8'd254) begin
            errors++;
            $display("FAIL wrap_sub: retired=%0d acc=%0d expected 2 retires ending 254",
                     r, acc_out);
        end
        checks++;
        if ({halted, busy, error} !== 3'b100) begin
            errors++;
            $display("FAIL hlt_state: halted/busy/error=%b expected 100", {halted, busy, error});
        end
        do_start();
        tick(); tick();
        checks++;
        if (!halted || (acc_log.size() - base) != 2) begin
            errors++;
            $display("FAIL hlt_start_ignored: halted=%b retires=%0d expected 1/2",
                     halted, acc_log.size() - base);
        end
        do_clear();
        checks++;
        if ({halted, busy, acc_out, instr_count} !== 18'd0) begin
            errors++;
            $display("FAIL hlt_clear: halted=%b busy=%b acc=%0d count=%0d expected all 0",
                     halted, busy, acc_out, instr_count);
        end
    endtask

    task automatic test_wrap_mul();
        int r, nb, nv, base;
        set_rom(8'hD4, 8'h45, 8'h45, 8'hE0, 4'd3);
        run = 1'b1;
        base = acc_log.size();
        run_until_idle(r, nb, nv);
        checks++;
        if (r != 3 || acc_log[base] !== 8'd20 || acc_log[base+1] !== 8'd100 ||
            acc_log[base+2] !== 8'd244) begin
            errors++;
            $display("FAIL wrap_mul: retired=%0d acc=%0d expected 20,100,244", r, acc_out);
        end
    endtask

    task automatic test_ldi();
        int r, nb, nv;
        set_rom(8'hC7, 8'h00, 8'h00, 8'h00, 4'd3);
        run = 1'b0;
        run_until_idle(r, nb, nv);
        checks++;
        if (nb != 3 || acc_out !== 8'd7 || ir_out !== 8'hC7 || ir_pc !== 4'd0) begin
            errors++;
            $display("FAIL ldi: cycles=%0d acc=%0d ir=%h pc=%0d expected 3/7/c7/0",
                     nb, acc_out, ir_out, ir_pc);
        end
    endtask

    task automatic test_stall();
        int  nb, nv, base, n;
        bit  stable;
        set_rom(8'h03, 8'h00, 8'h00, 8'h00, 4'd3);
        run = 1'b0;
        ready_delay = 3;
        do_clear();
        base = acc_log.size();
        do_start();
        nb = 0; nv = 0; stable = 1'b1;
        while (busy && nb < 60) begin
            nb++;
            if (alu_valid) begin
                nv++;
                if (alu_op !== 3'b000 || alu_a !== 8'd0 || alu_b !== 8'd3) stable = 1'b0;
            end
            tick();
        end
        checks++;
        if (nb != 7 || nv != 4) begin
            errors++;
            $display("FAIL stall_latency: cycles=%0d exec=%0d expected 7/4", nb, nv);
        end
        checks++;
        if (!stable || acc_out !== 8'd3) begin
            errors++;
            $display("FAIL stall_inputs: stable=%b acc=%0d expected 1/3", stable, acc_out);
        end
        ready_delay = 0;
        run_until_idle(n, nb, nv);
        checks++;
        if (nb != 4 || acc_out !== 8'd3) begin
            errors++;
            $display("FAIL alu_latency: cycles=%0d acc=%0d expected 4/3", nb, acc_out);
        end
    endtask

    task automatic test_timeout();
        int r, nb, nv;
        set_rom(8'hC9, 8'h03, 8'h00, 8'h00, 4'd3);
        run = 1'b1;
        never_ready = 1'b1;
        run_until_idle(r, nb, nv);
        checks++;
        if (nv != 15) begin
            errors++;
            $display("FAIL timeout_cycles: exec=%0d expected 15", nv);
        end
        checks++;
        if ({halted, error} !== 2'b11 || acc_out !== 8'd9 || r != 1 || instr_count !== 8'd1) begin
            errors++;
            $display("FAIL timeout_state: halted=%b error=%b acc=%0d retires=%0d expected 1/1/9/1",
                     halted, error, acc_out, r);
        end
        never_ready = 1'b0;
        tick(); tick();
        checks++;
        if (error !== 1'b1) begin
            errors++;
            $display("FAIL error_sticky: got %b expected 1", error);
        end
        do_clear();
        checks++;
        if ({error, halted} !== 2'b00) begin
            errors++;
            $display("FAIL error_clear: error/halted=%b expected 00", {error, halted});
        end
    endtask

    // Starts a program and waits (bounded) for the first ALU request.
    task automatic start_to_exec(output bit reached);
        int n;
        do_clear();
        do_start();
        n = 0;
        while (!alu_valid && n < 20) begin
            tick();
            n++;
        end
        reached = alu_valid;
        checks++;
        if (!reached) begin
            errors++;
            $display("FAIL exec_wait: alu_valid=%b expected 1", alu_valid);
        end
    endtask

    task automatic test_run_drop();
        bit ok;
        int n, base;
        set_rom(8'h03, 8'h03, 8'h00, 8'h00, 4'd1);
        run = 1'b1;
        ready_delay = 2;
        base = acc_log.size();
        start_to_exec(ok);
        run = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if ((acc_log.size() - base) != 1 || acc_out !== 8'd3 || instr_count !== 8'd1 ||
            busy || halted) begin
            errors++;
            $display("FAIL run_drop: retires=%0d acc=%0d count=%0d busy=%b expected 1/3/1/0",
                     acc_log.size() - base, acc_out, instr_count, busy);
        end
        ready_delay = 0;
    endtask

    task automatic test_clear_exec();
        bit ok;
        set_rom(8'hC9, 8'h03, 8'h00, 8'h00, 4'd1);
        run = 1'b1;
        ready_delay = 5;
        start_to_exec(ok);
        do_clear();
        checks++;
        if (alu_valid || busy || acc_out !== 8'd0) begin
            errors++;
            $display("FAIL clear_exec: valid=%b busy=%b acc=%0d expected 0/0/0",
                     alu_valid, busy, acc_out);
        end
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (acc_out !== 8'd0 || instr_count !== 8'd0 || busy) begin
            errors++;
            $display("FAIL clear_exec_after: acc=%0d count=%0d busy=%b expected 0/0/0",
                     acc_out, instr_count, busy);
        end
        ready_delay = 0;
    endtask

    task automatic test_reset_exec();
        bit ok;
        set_rom(8'hC9, 8'h03, 8'h00, 8'h00, 4'd1);
        run = 1'b1;
        never_ready = 1'b1;
        start_to_exec(ok);
        reset_n = 1'b0;
        #1;
        checks++;
        if (alu_valid || busy || acc_out !== 8'd0) begin
            errors++;
            $display("FAIL reset_exec: valid=%b busy=%b acc=%0d expected 0/0/0",
                     alu_valid, busy, acc_out);
        end
        @(negedge clock);
        reset_n = 1'b1;
        never_ready = 1'b0;
        run = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_program();
        test_wrap_sub();
        test_wrap_mul();
        test_ldi();
        test_stall();
        test_timeout();
        test_run_drop();
        test_clear_exec();
        test_reset_exec();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_sequencer.md
# cpu_sequencer

Fetch/decode/execute controller for the mode-1 CPU. It steps the program counter/ROM block one instruction at a time and latches each 8-bit instruction. It drives the ALU through a valid/ready handshake and holds the 8-bit accumulator. It sits between the PC/ROM block (the instruction source) and the ALU (the arithmetic resource), and exposes debug status to the top level.

## Interface
Parameters:
- `ALU_TIMEOUT`, default 15: maximum cycles the sequencer waits for `alu_ready` in EXEC before it flags an error; valid range 1–255.

Ports:
- `clock` in 1: single clock; all state updates on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: pulse; leaves IDLE and begins fetching.
- `run` in 1: level; while 1, the sequencer chains instructions; while 0, it returns to IDLE after the current instruction.
- `clear` in 1: synchronous; forces IDLE, zeroes `acc_out`, `instr_count`, `error`; takes priority over every other input.
- `instr_in` in 8: instruction from PC/ROM; bits [7:5] are the opcode, bits [4:0] the operand.
- `pc_in` in 4: current PC, used for debug capture only.
- `pc_ena` out 1: one-cycle advance pulse to the PC.
- `alu_valid` out 1: ALU request.
- `alu_op` out 3: opcode forwarded to the ALU.
- `alu_a` out 8: operand A, equal to the current accumulator.
- `alu_b` out 8: operand B, the zero-extended instruction operand.
- `alu_ready` in 1: ALU accepts the request and `alu_result` is valid in the same cycle.
- `alu_result` in 8: ALU result.
- `acc_out` out 8: accumulator.
- `ir_out` out 8: latched instruction register.
- `ir_pc` out 4: PC value at which `ir_out` was fetched.
- `instr_count` out 8: count of retired instructions; wraps modulo 256.
- `busy` out 1: 1 in every state except IDLE and HALT.
- `halted` out 1: 1 in HALT.
- `error` out 1: sticky ALU timeout flag.

## Operation
- Opcodes (package constants):
  - ADD=000, SUB=001, MUL=010, AND=011, OR=100, XOR=101: ALU ops.
  - LDI=110: `acc <= {3'b0, operand}`, handled without the ALU.
  - HLT=111: stop.
  - 8'h00 is ADD 0 and serves as NOP.
- States: IDLE, FETCH, DECODE, EXEC, ADVANCE, HALT.
  - IDLE: waits for `start`, then goes to FETCH.
  - FETCH: `ir <= instr_in`, `ir_pc <= pc_in`, then DECODE.
  - DECODE:
    - HLT: goes to HALT; does not pulse `pc_ena` and does not increment `instr_count`.
    - LDI: loads acc, then ADVANCE.
    - Any other opcode: EXEC.
  - EXEC:
    - `alu_valid`=1; `alu_op`, `alu_a`, `alu_b` stay stable until the handshake.
    - On `alu_valid && alu_ready`: `acc <= alu_result`, then ADVANCE.
    - Wait counter reaches `ALU_TIMEOUT` without ready: set `error`, go to HALT; acc unchanged.
  - ADVANCE: `pc_ena`=1 for this cycle only and `instr_count` increments. Next state is FETCH if `run`=1, else IDLE.
  - HALT: leaves only on `clear` or reset; `start` is ignored.
- Arithmetic is performed by the ALU. The sequencer requires results modulo 256: SUB underflow wraps and MUL keeps the low 8 bits.
- `run` dropping mid-instruction: the instruction completes (including its ADVANCE), then the sequencer goes to IDLE.
- `start` outside IDLE is ignored.
- `clear` during EXEC drops `alu_valid` on the next cycle; the request is abandoned and `acc_out` is not written.

## Timing
- Reset (`reset_n`=0, asynchronous): state IDLE and every output 0, including `pc_ena`, `alu_valid`, `acc_out`, `ir_out`, `ir_pc`, `instr_count`, `busy`, `halted`, `error`.
- `start` sampled in IDLE: FETCH on the next cycle.
- LDI: 3 cycles per instruction (FETCH, DECODE, ADVANCE).
- ALU op with `alu_ready` in the first EXEC cycle: 4 cycles. Each extra wait cycle adds 1.
- `acc_out` updates on the edge that ends the handshake cycle.
- `pc_ena` rises exactly once per retired non-HLT instruction.
- The PC advances on the edge ending ADVANCE, so `instr_in` is stable in the following FETCH.
- `alu_valid`, `busy`, `halted`, `pc_ena` are decoded from registered state only; there is no combinational input-to-output path except through `alu_ready`'s effect on the next state.
- Reset asserted mid-EXEC: `alu_valid` drops immediately (asynchronously).

## Structure
- Shared package `cpu_pkg`: opcode localparams, field widths (OPC=3, OPND=5, DATA=8, PC=4), and the state enum. The ALU imports the same opcodes.
- One sub-module: `seq_timeout`, a loadable down-counter with an expiry flag that is cleared whenever the FSM leaves EXEC. Everything else lives in the top FSM.

## Test plan
- Reset: hold `reset_n`=0 with random inputs → all outputs 0. Release, no `start` → IDLE, `busy`=0.
- Program: ROM ADD3, SUB2, MUL5, NOP with PC wrap at 3, `run`=1, ALU always ready.
  - First pass: acc 3, 1, 5, 5; instructions spaced 4 cycles apart.
  - Second pass: acc 8, 6, 30, 30; `instr_count`=8.
- Wrap arithmetic:
  - LDI 0, SUB 2 → acc 254.
  - LDI 20, MUL 5, MUL 5 → 100, then 244 (500 mod 256).
- ALU stall and timeout:
  - `alu_ready` delayed 3 cycles → inputs stable throughout, latency 7 cycles.
  - `alu_ready` never asserted with `ALU_TIMEOUT`=15 → `error`=1 and `halted`=1 after 15 EXEC cycles; acc unchanged; no `pc_ena`.
- HLT and control:
  - HLT in ROM → `halted`=1, `pc_ena` never pulses, `start` ignored; `clear` → IDLE with acc 0.
  - `run` dropped during EXEC → instruction retires, then IDLE.
- Reset mid-EXEC: `reset_n` low while `alu_valid`=1 → `alu_valid` drops that cycle and acc returns to 0.
